// File: rtl/leg_mem_pkg.sv
// Shared types and constants for the legacy memory subsystem.
// Contents:
//   arb_state_t  - RAM arbiter service state (IDLE -> ACCESS -> CAPTURE)
//   port_idx_t   - requester index (0 = instruction fetch, 1 = load/store)
//   PORT_IFETCH / PORT_LSU - named requester indices
//   other_port() - the opposite requester, used for round-robin tie break
package leg_mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2
   } arb_state_t;

   typedef logic port_idx_t;

   localparam port_idx_t PORT_IFETCH = 1'b0;
   localparam port_idx_t PORT_LSU    = 1'b1;

   function automatic port_idx_t other_port(input port_idx_t p);
      return port_idx_t'(~p);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester combinational round-robin picker.
// Ports:
//   req[1:0]  (in)  eligible requesters, bit i = port i
//   last_gnt  (in)  port that won the previous grant
//   gnt_valid (out) at least one requester is eligible
//   gnt_idx   (out) winning port; on a tie the port that did not win last time
module rr_arb2
   import leg_mem_pkg::*;
(
   input  logic [1:0] req,
   input  port_idx_t  last_gnt,
   output logic       gnt_valid,
   output port_idx_t  gnt_idx
);

   // Pick the single requester, or alternate away from last_gnt on a tie.
   always_comb begin
      gnt_valid = |req;
      gnt_idx   = PORT_IFETCH;
      case (req)
         2'b01:   gnt_idx = PORT_IFETCH;
         2'b10:   gnt_idx = PORT_LSU;
         2'b11:   gnt_idx = other_port(last_gnt);
         default: gnt_idx = PORT_IFETCH;
      endcase
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch port
// (p0) and the load/store port (p1). One access is in flight at a time and
// each takes exactly three cycles: IDLE (grant) -> ACCESS -> CAPTURE.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   pX_req/we/addr/wdata (in)  request fields, held until pX_ack
//   pX_rdata, pX_ack     (out) registered read data, one-cycle completion pulse
//   ram_cs/we/oe/addr/data_in (out) registered RAM command
//   ram_data_out         (in)  RAM read data, valid the cycle after the command
//   busy                 (out) high while in ACCESS or CAPTURE
module ram_arbiter
   import leg_mem_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  p0_req,
   input  logic                  p0_we,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   output logic                  p0_ack,
   input  logic                  p1_req,
   input  logic                  p1_we,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic                  p1_ack,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic                  ram_oe,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   output logic                  busy
);

   arb_state_t            state_q, state_d;
   port_idx_t             gnt_idx_q, gnt_idx_d;
   port_idx_t             last_gnt_q, last_gnt_d;
   logic                  op_we_q, op_we_d;
   logic                  ram_cs_q, ram_cs_d;
   logic                  ram_we_q, ram_we_d;
   logic                  ram_oe_q, ram_oe_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_data_in_q, ram_data_in_d;
   logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
   logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
   logic                  p0_ack_q, p0_ack_d;
   logic                  p1_ack_q, p1_ack_d;
   logic                  busy_q, busy_d;

   logic [1:0]            elig_s;
   logic                  gnt_valid_s;
   port_idx_t             win_s;

   // A requester still holding req during its own ack cycle is not eligible,
   // so it cannot be serviced twice for one request.
   assign elig_s = {p1_req & ~p1_ack_q, p0_req & ~p0_ack_q};

   rr_arb2 u_rr_arb2 (
      .req       (elig_s),
      .last_gnt  (last_gnt_q),
      .gnt_valid (gnt_valid_s),
      .gnt_idx   (win_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: fixed three-cycle service once granted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (gnt_valid_s) begin
               state_d = ACCESS;
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS:  state_d = CAPTURE;
         CAPTURE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath logic; RAM strobes default low so they are only
   // asserted for the ACCESS cycle.
   always_comb begin
      gnt_idx_d     = gnt_idx_q;
      last_gnt_d    = last_gnt_q;
      op_we_d       = op_we_q;
      ram_cs_d      = 1'b0;
      ram_we_d      = 1'b0;
      ram_oe_d      = 1'b0;
      ram_addr_d    = ram_addr_q;
      ram_data_in_d = ram_data_in_q;
      p0_rdata_d    = p0_rdata_q;
      p1_rdata_d    = p1_rdata_q;
      p0_ack_d      = 1'b0;
      p1_ack_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_valid_s) begin
               gnt_idx_d  = win_s;
               last_gnt_d = win_s;
               ram_cs_d   = 1'b1;
               if (win_s == PORT_LSU) begin
                  op_we_d       = p1_we;
                  ram_we_d      = p1_we;
                  ram_oe_d      = ~p1_we;
                  ram_addr_d    = p1_addr;
                  ram_data_in_d = p1_wdata;
               end else begin
                  op_we_d       = p0_we;
                  ram_we_d      = p0_we;
                  ram_oe_d      = ~p0_we;
                  ram_addr_d    = p0_addr;
                  ram_data_in_d = p0_wdata;
               end
            end else begin
               ram_cs_d = 1'b0;
            end
         end
         ACCESS: begin
            ram_cs_d = 1'b0;
         end
         CAPTURE: begin
            // Writes complete with an ack but leave rdata untouched.
            if (gnt_idx_q == PORT_LSU) begin
               p1_ack_d = 1'b1;
               if (!op_we_q) begin
                  p1_rdata_d = ram_data_out;
               end else begin
                  p1_rdata_d = p1_rdata_q;
               end
            end else begin
               p0_ack_d = 1'b1;
               if (!op_we_q) begin
                  p0_rdata_d = ram_data_out;
               end else begin
                  p0_rdata_d = p0_rdata_q;
               end
            end
         end
         default: begin
            ram_cs_d = 1'b0;
         end
      endcase
      busy_d = (state_d == ACCESS) || (state_d == CAPTURE);
   end

   // Datapath and output registers; last_gnt resets to port 1 so port 0
   // wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_idx_q     <= PORT_IFETCH;
         last_gnt_q    <= PORT_LSU;
         op_we_q       <= 1'b0;
         ram_cs_q      <= 1'b0;
         ram_we_q      <= 1'b0;
         ram_oe_q      <= 1'b0;
         ram_addr_q    <= {ADDR_WIDTH{1'b0}};
         ram_data_in_q <= {DATA_WIDTH{1'b0}};
         p0_rdata_q    <= {DATA_WIDTH{1'b0}};
         p1_rdata_q    <= {DATA_WIDTH{1'b0}};
         p0_ack_q      <= 1'b0;
         p1_ack_q      <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         gnt_idx_q     <= gnt_idx_d;
         last_gnt_q    <= last_gnt_d;
         op_we_q       <= op_we_d;
         ram_cs_q      <= ram_cs_d;
         ram_we_q      <= ram_we_d;
         ram_oe_q      <= ram_oe_d;
         ram_addr_q    <= ram_addr_d;
         ram_data_in_q <= ram_data_in_d;
         p0_rdata_q    <= p0_rdata_d;
         p1_rdata_q    <= p1_rdata_d;
         p0_ack_q      <= p0_ack_d;
         p1_ack_q      <= p1_ack_d;
         busy_q        <= busy_d;
      end
   end

   assign ram_cs      = ram_cs_q;
   assign ram_we      = ram_we_q;
   assign ram_oe      = ram_oe_q;
   assign ram_addr    = ram_addr_q;
   assign ram_data_in = ram_data_in_q;
   assign p0_rdata    = p0_rdata_q;
   assign p1_rdata    = p1_rdata_q;
   assign p0_ack      = p0_ack_q;
   assign p1_ack      = p1_ack_q;
   assign busy        = busy_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter that shares the single-port RAM (cs/we/oe, synchronous write, registered read) between the instruction-fetch requester (port 0) and the load/store requester (port 1).
- Round-robin selection, one RAM access in flight at a time.
- Registered RAM control outputs and a per-port req/ack handshake with registered read data.
- Sits between the CPU core memory interfaces and the RAM instance.

Parameters:
- DATA_WIDTH, 64, width of the data bus on both ports and on the RAM.
- ADDR_WIDTH, 12, width of the word address on both ports and on the RAM.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- p0_req / p1_req  input  1  access request; held with its command fields until the matching ack.
- p0_we / p1_we  input  1  1 = write, 0 = read.
- p0_addr / p1_addr  input  ADDR_WIDTH  word address.
- p0_wdata / p1_wdata  input  DATA_WIDTH  write data.
- p0_rdata / p1_rdata  output  DATA_WIDTH  read data; valid while the matching ack is high, held afterwards.
- p0_ack / p1_ack  output  1  one-cycle completion pulse.
- ram_cs  output  1  RAM chip select.
- ram_we  output  1  RAM write enable.
- ram_oe  output  1  RAM output enable.
- ram_addr  output  ADDR_WIDTH  RAM address.
- ram_data_in  output  DATA_WIDTH  RAM write data.
- ram_data_out  input  DATA_WIDTH  RAM read data; valid the cycle after a read command is sampled.
- busy  output  1  high in ACCESS and CAPTURE.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - All outputs 0.
  - State IDLE.
  - last_gnt = 1, so port 0 wins the first tie.
- States: IDLE -> ACCESS -> CAPTURE -> IDLE. Fixed 3-cycle service per access.
- IDLE:
  - Eligible port = req high AND its ack not currently high. This masks a requester that has not yet dropped req after its ack.
  - If no port is eligible: stay in IDLE, ram_cs = 0, ram_we = 0, ram_oe = 0.
  - If one port is eligible: grant it.
  - If both are eligible: grant the port != last_gnt.
  - On grant, at the clock edge:
    - Register the winner's addr/wdata into ram_addr/ram_data_in.
    - ram_cs = 1, ram_we = we, ram_oe = ~we.
    - Latch gnt_idx; last_gnt = winner.
    - Go to ACCESS.
- ACCESS:
  - RAM sees a stable command for the whole cycle and performs the write or read at the end edge.
  - At that edge: ram_cs, ram_we and ram_oe go to 0. ram_addr and ram_data_in hold.
  - Go to CAPTURE.
- CAPTURE:
  - For a read, ram_data_out is valid.
  - At the edge: pX_rdata <= ram_data_out (read only) and pX_ack <= 1 for gnt_idx. Go to IDLE.
- ack is high for exactly the first IDLE cycle after CAPTURE, then 0.
- Latency: req first sampled at edge N -> ack high during the cycle after edge N+2. Sustained throughput is 1 access per 3 cycles.
- Alternation: with both ports requesting continuously, grants alternate 0,1,0,1. Back-to-back service of the other port starts in the ack cycle.
- Write rdata: pX_rdata is unchanged on write completions.
- Request fields sampled only at the grant edge. Changes to them during ACCESS/CAPTURE are ignored. Dropping req mid-service does not abort the access; ack is still pulsed.
- Port 0 may issue writes; it is not restricted to reads.
- Reset mid-operation: state -> IDLE, ram_cs/ram_we/ram_oe forced 0 immediately (asynchronous). A write in ACCESS with no edge yet taken is not performed. No ack is issued for the aborted access.
- ram_addr wraps naturally. There is no range checking; all 2^ADDR_WIDTH addresses are valid.

Decomposition:
- Package leg_mem_pkg:
  - arb_state_t enum {IDLE, ACCESS, CAPTURE}.
  - port_idx_t (1 bit).
  - Constants PORT_IFETCH = 0 and PORT_LSU = 1.
- Sub-module rr_arb2: combinational round-robin pick. Inputs: req[1:0], last_gnt. Outputs: gnt_valid, gnt_idx. Reusable for later memory-mapped peripherals.

Test Plan:
- Single write then read: p1 writes addr 0x018 data 0x1234, then reads 0x018. Required: ram_cs/ram_we high exactly 1 cycle with ram_addr = 0x018. p1_ack 3 cycles after req. p1_rdata = 0x1234 at the read ack.
- Simultaneous requests out of reset: p0 reads 0x000 (preloaded 0xA5) and p1 writes 0x101 = 0x123456789AB. Required: p0 served first (ack cycle 3, rdata 0xA5), p1 acked at cycle 6. A subsequent p1 read of 0x101 returns 0x123456789AB.
- Continuous contention: both reqs held high for 4 services. Required: ack order p0, p1, p0, p1, with exactly one ack per 3 cycles. A port never acks twice in a row while the other port is requesting.
- Held req masking: p0 keeps req high in its ack cycle with p1 idle. Required: no grant in the ack cycle; the next grant happens the following cycle (one extra cycle), not a duplicate in the ack cycle.
- Reset during ACCESS: p1 write of 0x019 = 0xDEAD, rst_n low mid-ACCESS. Required: ram_cs drops immediately, no p1_ack, mem[0x019] unchanged. After release, last_gnt = 1 and all outputs are 0.
- Mid-service field change: p0 read of 0x018, with p0_addr changed to 0x019 during ACCESS. Required: ram_addr stays 0x018 and p0_rdata = M[0x018].
